// File: rtl/seq_sched_pkg.sv
// Shared definitions for the serial pattern scheduler: FSM encodings and default geometry.
// Pure declarations; no timing or backpressure of its own.
package seq_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF  = 4;
  localparam int CNT_W_DEF  = 8;
  localparam logic [PAT_W_DEF-1:0] PAT_RESET_DEF = 4'b1011;

endpackage

// File: rtl/pattern_match_core.sv
// Overlapping Mealy matcher over a serial bit stream; match is combinational on the current bit.
// No backpressure: consumes one bit per cycle whenever bit_valid is high.
module pattern_match_core
  import seq_sched_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  history;
  logic [PAT_W-2:0]  history_nxt;
  logic [FILL_W-1:0] fill;

  generate
    if (PAT_W == 2) begin : g_hist_min
      assign history_nxt = bit_in;
    end else begin : g_hist_wide
      assign history_nxt = {history[PAT_W-3:0], bit_in};
    end
  endgenerate

  // fill gates the compare so a partially filled history never matches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      history <= '0;
      fill    <= '0;
    end else if (clr) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_valid) begin
      history <= history_nxt;
      if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  assign match = bit_valid && (fill == FILL_MAX) && ({history, bit_in} == pattern);

endmodule

// File: rtl/seq_stream_scheduler.sv
// Serialises words MSB-first into a pattern matcher and counts matches per frame; first bit 1 cycle after accept, done 1 cycle after last bit.
// in_ready only in IDLE or on the final bit of a non-last word, so back-to-back words stream gaplessly.
module seq_stream_scheduler
  import seq_sched_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W  = PAT_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter logic [PAT_W-1:0] PAT_RESET = PAT_W'(PAT_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'(WORD_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              last_q;
  logic [PAT_W-1:0]  pattern;
  logic              accept;
  logic              frame_start;
  logic              cfg_take;

  assign in_ready    = (state == IDLE) || ((state == SHIFT) && (bit_cnt == '0) && !last_q);
  assign accept      = in_valid && in_ready;
  // an accept from IDLE while busy is a mid-frame word after a producer stall
  assign frame_start = accept && (state == IDLE) && !busy;
  assign cfg_take    = cfg_we && (state == IDLE) && !busy && !accept;

  assign bit_valid = (state == SHIFT);
  assign bit_out   = shreg[WORD_W-1];
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          if (accept) begin
            state_nxt = SHIFT;
          end else if (last_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      shreg   <= in_data;
      bit_cnt <= BC_LOAD;
      last_q  <= in_last;
    end else if (state == SHIFT) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
      if (bit_cnt != '0) begin
        bit_cnt <= bit_cnt - BC_W'(1);
      end
    end else if (state == DONE) begin
      last_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
    end else if (frame_start) begin
      busy <= 1'b1;
    end else if (state == DONE) begin
      busy <= 1'b0;
    end
  end

  // count saturates rather than wrapping so a long frame never reports a small value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= '0;
    end else if (frame_start) begin
      match_count <= '0;
    end else if (match && !(&match_count)) begin
      match_count <= match_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= PAT_RESET;
    end else if (cfg_take) begin
      pattern <= cfg_pattern;
    end
  end

  pattern_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_start),
    .bit_valid (bit_valid),
    .bit_in    (bit_out),
    .pattern   (pattern),
    .match     (match)
  );

endmodule

// File: doc/seq_stream_scheduler.md
Name: seq_stream_scheduler

Overview:
- Controller that sequences a serial overlapping-pattern detector.
- Accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per clock.
- Drives a programmable PAT_W-bit Mealy match core and counts matches per frame. A frame is one or more words, terminated by in_last.
- Sits between a word-wide producer and the serial detection path. Replaces hand-driven d_in stimulus.

Parameters:
WORD_W, 8, input word width (bits serialised per word)
PAT_W, 4, pattern length in bits (2..WORD_W)
CNT_W, 8, match counter width
PAT_RESET, 4'b1011, pattern loaded at reset (PAT_W bits)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (low = reset)
cfg_we  in  1  pattern write strobe
cfg_pattern  in  PAT_W  new pattern, MSB = oldest bit
in_valid  in  1  word available
in_ready  out  1  block can accept word this cycle
in_data  in  WORD_W  word, MSB shifted first
in_last  in  1  word is last of frame
bit_out  out  1  current serial bit
bit_valid  out  1  bit_out meaningful this cycle
match  out  1  Mealy match on current bit
match_count  out  CNT_W  matches in current/last frame
busy  out  1  frame in progress
done  out  1  one-cycle frame-complete pulse

Behaviour:
- Single clock. Reset is asynchronous and active-low, on port rst with clock clk.
- Reset state:
  - state=IDLE; shift reg, bit counter, history, history fill counter, match_count, busy, done and last flag all 0.
  - pattern=PAT_RESET.
  - Outputs: in_ready=1 (IDLE), bit_valid=0, match=0.
- States: IDLE, SHIFT, DONE (encodings in package).
- Handshake:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==SHIFT && bit_cnt==0 && !last_q).
  - in_data, in_last and in_valid must hold while in_valid && !in_ready.
- Accept:
  - Load shreg<=in_data, bit_cnt<=WORD_W-1, last_q<=in_last; state<=SHIFT.
  - If accepted from IDLE (frame start): clear history, fill counter and match_count; busy<=1.
- SHIFT, every cycle:
  - bit_valid=1, bit_out=shreg[MSB].
  - Shift shreg left and decrement bit_cnt.
  - history<={history[PAT_W-3:0],bit_out}. Fill counter increments, saturating at PAT_W-1.
  - When bit_cnt==0:
    - word accepted this cycle -> reload and stay in SHIFT, giving gapless bit_valid;
    - last_q=1 -> DONE;
    - otherwise -> IDLE (busy stays 1).
- match (combinational, Mealy):
  - match = bit_valid && fill==PAT_W-1 && {history,bit_out}==pattern.
  - Overlapping matches count; history carries across words within a frame.
- match_count increments on match at the clock edge and saturates at all-ones (no wrap).
- DONE (one cycle): done=1, busy<=0, in_ready=0, bit_valid=0; then -> IDLE.
- match_count holds its value until the next frame-start accept.
- cfg_we:
  - Pattern updates at the edge only when state==IDLE && !busy && no accept in the same cycle.
  - Otherwise the write is ignored (no queuing).
- Reset mid-operation: immediate return to reset values. A partial frame is discarded with no done pulse; pattern reverts to PAT_RESET.
- Latency: first bit_out the cycle after accept. done asserts the cycle after the final bit.

Decomposition:
- Package seq_sched_pkg holds:
  - state encodings IDLE/SHIFT/DONE;
  - default PAT_RESET;
  - PAT_W/WORD_W defaults.
- Sub-module pattern_match_core holds the history register, fill counter and compare, with ports clk, rst, clr, bit_valid, bit_in, pattern, match.
- The scheduler owns the handshake, shifting, counter and FSM.

Test Plan:
- Reset: rst low mid-sim -> in_ready=1, bit_valid=0, match=0, match_count=0, busy=0, done=0, pattern=1011.
- Single word, default pattern: in_data=8'b1011_0110, in_last=1.
  - bit_out sequence 1,0,1,1,0,1,1,0.
  - match high on bits 4 and 7 (1-based).
  - match_count=2; done pulses the cycle after bit 8.
- Cross-word, back-to-back: word 8'b0000_0101 (last=0), then 8'b1000_0000 (last=1), presented with in_valid held.
  - Second word accepted in the final shift cycle of the first; no bit_valid gap.
  - match on bit 1 of the second word; count=1.
- Config:
  - cfg_we=1 with 4'b1111 while busy -> ignored (pattern stays 1011).
  - Same write in idle, then 8'hFF last=1 -> matches on bits 4..8, count=5.
- Saturation: CNT_W=3, pattern 1111, frame of two 8'hFF words -> 13 raw matches, match_count=7 and holding.
- Reset mid-SHIFT:
  - rst low on bit 3 -> no done, busy=0, pattern=1011.
  - Next frame 8'b1011_0000 matches once at bit 4, with no stale history.
